// File: rtl/cell_hist_accum.sv
`default_nettype none
// ============================================================================
//  Module      : cell_hist_accum
//  Description : Accumulates raster-order gradient pixels into per-cell
//                orientation histograms (BINS bins plus a magnitude-sum bin)
//                and streams completed cells out over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module cell_hist_accum #(
    parameter int IMAGE_WIDTH        = 640,
    parameter int IMAGE_HEIGHT       = 480,
    parameter int CELL_ROW_PIXELS    = 8,
    parameter int CELL_COLUMN_PIXELS = 8,
    parameter int MAG_WIDTH          = 8,
    parameter int BIN_IDX_WIDTH      = 4,
    parameter int BIN_WIDTH          = 14,
    parameter int BINS               = 9,
    parameter int HISTOGRAM_WIDTH    = BIN_WIDTH * (BINS + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [MAG_WIDTH-1:0]       magnitude,
    input  logic [BIN_IDX_WIDTH-1:0]   bin,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [HISTOGRAM_WIDTH-1:0] cell_histogram
);

    localparam int c_CELLS   = IMAGE_WIDTH / CELL_ROW_PIXELS;
    localparam int c_BANDS   = IMAGE_HEIGHT / CELL_COLUMN_PIXELS;
    localparam int c_SUBX_W  = (CELL_ROW_PIXELS > 1) ? $clog2(CELL_ROW_PIXELS) : 1;
    localparam int c_CELLX_W = (c_CELLS > 1) ? $clog2(c_CELLS) : 1;
    localparam int c_PHASE_W = (CELL_COLUMN_PIXELS > 1) ? $clog2(CELL_COLUMN_PIXELS) : 1;
    localparam int c_BAND_W  = (c_BANDS > 1) ? $clog2(c_BANDS) : 1;

    localparam logic [c_SUBX_W-1:0]  c_SUBX_LAST  = c_SUBX_W'(CELL_ROW_PIXELS - 1);
    localparam logic [c_CELLX_W-1:0] c_CELLX_LAST = c_CELLX_W'(c_CELLS - 1);
    localparam logic [c_PHASE_W-1:0] c_PHASE_LAST = c_PHASE_W'(CELL_COLUMN_PIXELS - 1);
    localparam logic [c_BAND_W-1:0]  c_BAND_LAST  = c_BAND_W'(c_BANDS - 1);

    // Column and row are kept factored: col = cell_x*CELL_ROW_PIXELS + sub_x,
    // row = band*CELL_COLUMN_PIXELS + phase.
    logic [c_SUBX_W-1:0]        r_sub_x;
    logic [c_CELLX_W-1:0]       r_cell_x;
    logic [c_PHASE_W-1:0]       r_phase;
    logic [c_BAND_W-1:0]        r_band;
    logic [HISTOGRAM_WIDTH-1:0] r_seg;
    logic [HISTOGRAM_WIDTH-1:0] r_hist;
    logic                       r_out_valid;
    logic [HISTOGRAM_WIDTH-1:0] r_buf [c_CELLS];

    logic [BIN_WIDTH-1:0]       w_mag_ext;
    logic                       w_bin_ok;
    logic                       w_accept;
    logic                       w_close;
    logic [HISTOGRAM_WIDTH-1:0] w_buf_rd;
    logic [HISTOGRAM_WIDTH-1:0] w_seg_next;
    logic [HISTOGRAM_WIDTH-1:0] w_merge;
    logic [HISTOGRAM_WIDTH-1:0] w_final;

    function automatic logic [BIN_WIDTH-1:0] sat_add(
        input logic [BIN_WIDTH-1:0] a,
        input logic [BIN_WIDTH-1:0] b
    );
        logic [BIN_WIDTH:0] w_sum;
        w_sum = {1'b0, a} + {1'b0, b};
        return w_sum[BIN_WIDTH] ? {BIN_WIDTH{1'b1}} : w_sum[BIN_WIDTH-1:0];
    endfunction

    generate
        if (MAG_WIDTH <= BIN_WIDTH) begin : g_mag_narrow
            assign w_mag_ext = BIN_WIDTH'(magnitude);
        end else begin : g_mag_wide
            assign w_mag_ext = (|magnitude[MAG_WIDTH-1:BIN_WIDTH]) ? {BIN_WIDTH{1'b1}}
                                                                    : magnitude[BIN_WIDTH-1:0];
        end
    endgenerate

    assign in_ready       = !r_out_valid || out_ready;
    assign w_accept       = in_valid && in_ready;
    assign w_close        = w_accept && (r_sub_x == c_SUBX_LAST);
    assign w_bin_ok       = (32'(bin) < BINS);
    assign w_buf_rd       = r_buf[r_cell_x];
    assign out_valid      = r_out_valid;
    assign cell_histogram = r_hist;

    // Segment including the current pixel, and that segment merged with the
    // partial histogram already buffered for this cell column.
    generate
        for (genvar k = 0; k < BINS; k++) begin : g_bin
            assign w_seg_next[k*BIN_WIDTH +: BIN_WIDTH] =
                (w_bin_ok && (32'(bin) == k)) ? sat_add(r_seg[k*BIN_WIDTH +: BIN_WIDTH], w_mag_ext)
                                              : r_seg[k*BIN_WIDTH +: BIN_WIDTH];
        end
        for (genvar k = 0; k <= BINS; k++) begin : g_merge
            assign w_merge[k*BIN_WIDTH +: BIN_WIDTH] =
                sat_add(w_buf_rd[k*BIN_WIDTH +: BIN_WIDTH], w_seg_next[k*BIN_WIDTH +: BIN_WIDTH]);
        end
    endgenerate

    assign w_seg_next[BINS*BIN_WIDTH +: BIN_WIDTH] =
        w_bin_ok ? sat_add(r_seg[BINS*BIN_WIDTH +: BIN_WIDTH], w_mag_ext)
                 : r_seg[BINS*BIN_WIDTH +: BIN_WIDTH];

    assign w_final = (r_phase == '0) ? w_seg_next : w_merge;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sub_x     <= '0;
            r_cell_x    <= '0;
            r_phase     <= '0;
            r_band      <= '0;
            r_seg       <= '0;
            r_hist      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_seg <= w_close ? '0 : w_seg_next;
                if (r_sub_x == c_SUBX_LAST) begin
                    r_sub_x <= '0;
                    if (r_cell_x == c_CELLX_LAST) begin
                        r_cell_x <= '0;
                        if (r_phase == c_PHASE_LAST) begin
                            r_phase <= '0;
                            r_band  <= (r_band == c_BAND_LAST) ? '0 : r_band + 1'b1;
                        end else begin
                            r_phase <= r_phase + 1'b1;
                        end
                    end else begin
                        r_cell_x <= r_cell_x + 1'b1;
                    end
                end else begin
                    r_sub_x <= r_sub_x + 1'b1;
                end
            end
            // A close can only happen when the output slot is free or draining.
            if (w_close && (r_phase == c_PHASE_LAST)) begin
                r_hist      <= w_final;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Partial-histogram line buffer; phase 0 overwrites so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_close && (r_phase != c_PHASE_LAST)) begin
            r_buf[r_cell_x] <= w_final;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cell_hist_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cell_hist_accum
//  Description : Directed self-checking bench for cell_hist_accum on a
//                16x16 image with 12-bit bins.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cell_hist_accum;

    localparam int c_W  = 16;
    localparam int c_BW = 12;
    localparam int c_HW = c_BW * 10;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [7:0]      magnitude = '0;
    logic [3:0]      bin = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [c_HW-1:0] cell_histogram;

    int vectors = 0;
    int miscompares = 0;
    logic [c_HW-1:0] q[$];
    logic [c_HW-1:0] h1, h2a, h2b, h3, h5a, h5b, h5c, h5d, held;

    always #5 clk = ~clk;

    cell_hist_accum #(
        .IMAGE_WIDTH(c_W), .IMAGE_HEIGHT(16), .CELL_ROW_PIXELS(8), .CELL_COLUMN_PIXELS(8),
        .MAG_WIDTH(8), .BIN_IDX_WIDTH(4), .BIN_WIDTH(c_BW), .BINS(9), .HISTOGRAM_WIDTH(c_HW)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .magnitude(magnitude), .bin(bin), .out_valid(out_valid),
        .out_ready(out_ready), .cell_histogram(cell_histogram)
    );

    // Output handshakes are recorded half a cycle before the edge that completes them.
    always begin
        @(negedge clk);
        #1;
        if (out_valid && out_ready) q.push_back(cell_histogram);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [c_HW-1:0] put(input logic [c_HW-1:0] h, input int k, input int v);
        logic [31:0] w_v;
        w_v = v;
        h[k*c_BW +: c_BW] = w_v[c_BW-1:0];
        return h;
    endfunction

    function automatic logic displaced(input int row, input int col);
        return (col == 3 && row % 2 == 0) || (col == 12 && row == 5);
    endfunction

    function automatic logic [3:0] pix_bin(input int mode, input int row, input int col);
        case (mode)
            2:       return 4'(col % 9);
            3:       return 4'd0;
            5:       return displaced(row, col) ? 4'(9 + row % 7) : 4'd2;
            6:       return 4'd5;
            default: return 4'd2;
        endcase
    endfunction

    function automatic logic [7:0] pix_mag(input int mode, input int row, input int col);
        case (mode)
            3:       return 8'd255;
            5:       return displaced(row, col) ? 8'd200 : 8'd1;
            6:       return 8'd3;
            default: return 8'd1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [c_HW+1:0] obs, input logic [c_HW+1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input int mode, input int p, input bit rnd_gap);
        int row = p / c_W;
        int col = p % c_W;
        int guard = 0;
        @(negedge clk);
        in_valid  = 1'b1;
        magnitude = pix_mag(mode, row, col);
        bin       = pix_bin(mode, row, col);
        #1;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 200) check("in_ready_timeout", 1'b1, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (rnd_gap) repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    task automatic run(input int mode, input int first, input int last, input bit rnd_gap);
        for (int p = first; p <= last; p++) push(mode, p, rnd_gap);
    endtask

    task automatic check_frame(input string tag, input logic [c_HW-1:0] e0, input logic [c_HW-1:0] e1,
                               input logic [c_HW-1:0] e2, input logic [c_HW-1:0] e3);
        logic [c_HW-1:0] exp [4];
        exp = '{e0, e1, e2, e3};
        repeat (3) @(posedge clk);
        check({tag, "_count"}, q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < q.size()) check($sformatf("%s_cell%0d", tag, i), q[i], exp[i]);
        end
        q.delete();
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check(tag, {out_valid, in_ready, cell_histogram}, {1'b0, 1'b1, {c_HW{1'b0}}});
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        h1 = put(put('0, 2, 64), 9, 64);
        h2a = '0;
        for (int k = 0; k < 8; k++) h2a = put(h2a, k, 8);
        h2a = put(h2a, 9, 64);
        h2b = '0;
        for (int k = 0; k < 7; k++) h2b = put(h2b, k, 8);
        h2b = put(put(h2b, 8, 8), 9, 64);
        h3  = put(put('0, 0, 4095), 9, 4095);
        h5a = put(put('0, 2, 60), 9, 60);
        h5b = put(put('0, 2, 63), 9, 63);
        h5c = put(put('0, 2, 60), 9, 60);
        h5d = put(put('0, 2, 64), 9, 64);

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_state", {out_valid, in_ready, cell_histogram}, {1'b0, 1'b1, {c_HW{1'b0}}});
        rst = 1'b1;

        // Uniform bin 2, with first-output timing
        run(1, 0, 118, 1'b0);
        check("s1_before_first", out_valid, 1'b0);
        run(1, 119, 119, 1'b0);
        check("s1_first_valid", {out_valid, cell_histogram}, {1'b1, h1});
        run(1, 120, 126, 1'b0);
        check("s1_before_second", out_valid, 1'b0);
        run(1, 127, 127, 1'b0);
        check("s1_second_valid", out_valid, 1'b1);
        run(1, 128, 255, 1'b0);
        check_frame("s1", h1, h1, h1, h1);

        // bin = col mod 9
        run(2, 0, 255, 1'b0);
        check_frame("s2", h2a, h2b, h2a, h2b);

        // Saturation
        run(3, 0, 255, 1'b0);
        check_frame("s3", h3, h3, h3, h3);

        // Backpressure on the first histogram
        out_ready = 1'b0;
        run(1, 0, 119, 1'b0);
        held = cell_histogram;
        check("s4_held_value", held, h1);
        @(negedge clk);
        in_valid  = 1'b1;
        magnitude = 8'd1;
        bin       = 4'd2;
        for (int i = 0; i < 20; i++) begin
            #1;
            check("s4_stall", {out_valid, in_ready, cell_histogram}, {1'b1, 1'b0, h1});
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("s4_release_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        run(1, 121, 255, 1'b0);
        check_frame("s4", h1, h1, h1, h1);

        // Invalid bins mixed in, random gaps
        run(5, 0, 255, 1'b1);
        check_frame("s5", h5a, h5b, h5c, h5d);

        // Async reset with a pending histogram, then with a partial segment
        out_ready = 1'b0;
        run(1, 0, 119, 1'b0);
        check("s6_pending", out_valid, 1'b1);
        pulse_reset("s6_reset_pending");
        out_ready = 1'b1;
        q.delete();
        run(6, 0, 99, 1'b0);
        check("s6_partial_no_out", out_valid, 1'b0);
        pulse_reset("s6_reset_partial");
        run(1, 0, 255, 1'b0);
        check_frame("s6", h1, h1, h1, h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
